mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle MIPS control FSM that drives the datapath ALU and consumes its `Zero` flag. It sequences fetch, decode, execute, memory and writeback. It also generates every mux select, write enable and the 3-bit ALU operation code. Memory accesses use a ready handshake. The block sits beside the register file, ALU and instruction register in the processor top level.

## Interface
- No parameters.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `OPCODE` in 6: IR[31:26], stable from DECODE until return to FETCH.
- `FUNCT` in 6: IR[5:0].
- `ZERO` in 1: ALU `Zero` flag, combinational from the current cycle's ALU inputs.
- `MEM_READY` in 1: memory completes the current access this cycle.
- `PC_EN` out 1: PC load enable.
- `IR_WRITE` out 1: instruction register load.
- `IOR_D` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `MEM_RD`, `MEM_WR` out 1 each: memory read and write requests.
- `REG_DST` out 1: 0 = rt, 1 = rd.
- `MEM_TO_REG` out 1: 0 = ALUOut, 1 = MDR.
- `REG_WRITE` out 1: register file write.
- `ALU_SRC_A` out 1: 0 = PC, 1 = A.
- `ALU_SRC_B` out 2: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `ALU_SEL` out 3: ALU operation code. 000 add, 001 sub, 010 and, 011 or, 100 xor, 111 signed slt.
- `PC_SRC` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ILLEGAL` out 1: unsupported opcode or funct, combinational.

## Operation
- The state register is 4 bits. Outputs are Moore decodes of the state, except `PC_EN` and `IR_WRITE`, which also depend on `MEM_READY`/`ZERO`/`OPCODE`. Any output not listed for a state is 0.
- **FETCH (0):** `MEM_RD`=1, `IOR_D`=0, `ALU_SRC_A`=0, `ALU_SRC_B`=01, `ALU_SEL`=000, `PC_SRC`=00.
  - If `MEM_READY`=1: `IR_WRITE`=1, `PC_EN`=1, next state DECODE.
  - Otherwise hold.
- **DECODE (1):** `ALU_SRC_A`=0, `ALU_SRC_B`=11, `ALU_SEL`=000; the branch target goes to ALUOut. Next state by `OPCODE`:
  - 000000 → EXEC_R.
  - 100011 / 101011 → MEM_ADDR.
  - 000100 / 000101 → BRANCH.
  - 001000 / 001010 → EXEC_I.
  - 000010 → JUMP (see Configuration).
  - Anything else: `ILLEGAL`=1, next state FETCH.
- **MEM_ADDR (2):** `ALU_SRC_A`=1, `ALU_SRC_B`=10, `ALU_SEL`=000. Next: MEM_READ for lw, MEM_WRITE for sw.
- **MEM_READ (3):** `MEM_RD`=1, `IOR_D`=1. Hold until `MEM_READY`, then MEM_WB.
- **MEM_WB (4):** `REG_WRITE`=1, `REG_DST`=0, `MEM_TO_REG`=1. Next FETCH.
- **MEM_WRITE (5):** `MEM_WR`=1, `IOR_D`=1. Hold until `MEM_READY`, then FETCH.
- **EXEC_R (6):** `ALU_SRC_A`=1, `ALU_SRC_B`=00. `FUNCT` maps to `ALU_SEL`:
  - 100000 → 000, 100010 → 001, 100100 → 010, 100101 → 011, 100110 → 100, 101010 → 111.
  - Next state R_WB.
  - Any other funct: `ALU_SEL`=000, `ILLEGAL`=1, next FETCH with no writeback.
- **R_WB (7):** `REG_WRITE`=1, `REG_DST`=1, `MEM_TO_REG`=0. Next FETCH.
- **BRANCH (8):** `ALU_SRC_A`=1, `ALU_SRC_B`=00, `ALU_SEL`=001, `PC_SRC`=01.
  - `PC_EN`=`ZERO` for beq, `PC_EN`=~`ZERO` for bne.
  - Next FETCH.
- **EXEC_I (9):** `ALU_SRC_A`=1, `ALU_SRC_B`=10. `ALU_SEL`=000 for addi, 111 for slti. Next I_WB.
- **I_WB (10):** `REG_WRITE`=1, `REG_DST`=0, `MEM_TO_REG`=0. Next FETCH.
- **JUMP (11):** `PC_SRC`=10, `PC_EN`=1. Next FETCH.
- Unused encodings 12–15 go to FETCH with all outputs 0.

## Timing
- **Reset:** asynchronous to FETCH. While `RST_N`=0, `PC_EN`, `IR_WRITE`, `MEM_WR` and `REG_WRITE` are forced to 0. The other outputs take their FETCH values (`MEM_RD`=1, `ALU_SRC_B`=01, all others 0). Deassertion mid-instruction restarts at FETCH; no partial writeback.
- **Cycles per instruction** with `MEM_READY` always 1:
  - lw 5; sw 4; R-type 4; addi/slti 4; beq/bne 3; j 3.
  - Each low-`MEM_READY` cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- **Handshake:** `MEM_RD`/`MEM_WR` and `IOR_D` stay constant for the whole wait. The access completes in the cycle where the request and `MEM_READY` are both high. `MEM_READY` is ignored in all other states.
- **`ILLEGAL`:** high for exactly one cycle (DECODE or EXEC_R). No register, PC or memory write results.

## Configuration
- `MIPS_JUMP_EN` defined: opcode 000010 takes DECODE → JUMP → FETCH as above.
- Undefined: the JUMP state is not compiled, and 000010 is treated as illegal (`ILLEGAL`=1 in DECODE, return to FETCH).

## Test plan
- **Reset:** assert `RST_N`=0 mid-EXEC_R → immediate FETCH; `REG_WRITE`=0 and `PC_EN`=0 during reset; first fetch after release.
- **R-type:** `OPCODE`=000000 with each of the six functs, `MEM_READY`=1 → `ALU_SEL` = 000/001/010/011/100/111 in EXEC_R; `REG_WRITE`=1, `REG_DST`=1 in the following cycle; 4 cycles total.
- **Load stall:** lw with `MEM_READY` low for 3 cycles in MEM_READ → `MEM_RD`=1, `IOR_D`=1 held 4 cycles; MEM_WB then FETCH; 8 cycles total.
- **Branch:** beq with `ZERO`=1 → `PC_EN`=1, `PC_SRC`=01. bne with `ZERO`=1 → `PC_EN`=0. Both return to FETCH after 3 cycles.
- **Illegal:** `OPCODE`=111111 → `ILLEGAL`=1 in DECODE, then FETCH. funct 000001 → `ILLEGAL`=1 in EXEC_R with no `REG_WRITE`.
- **Jump:** `OPCODE`=000010 with `MIPS_JUMP_EN` → `PC_EN`=1, `PC_SRC`=10 in cycle 3. Without the macro → `ILLEGAL`=1 in DECODE.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM with ready-handshaked memory.
// Define MIPS_JUMP_EN to support j (opcode 000010); otherwise j is decoded as illegal.
module mips_multicycle_control (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [5:0] OPCODE,
  input  logic [5:0] FUNCT,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       PC_EN,
  output logic       IR_WRITE,
  output logic       IOR_D,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       REG_DST,
  output logic       MEM_TO_REG,
  output logic       REG_WRITE,
  output logic       ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] ALU_SEL,
  output logic [1:0] PC_SRC,
  output logic       ILLEGAL
);
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    EXEC_I    = 4'd9,
`ifdef MIPS_JUMP_EN
    I_WB      = 4'd10,
    JUMP      = 4'd11
`else
    I_WB      = 4'd10
`endif
  } state_t;
  state_t state_q, state_d;
  logic pc_en, ir_write;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state_q <= FETCH;
    else        state_q <= state_d;
  always_comb begin
    state_d    = FETCH;
    pc_en      = 1'b0;
    ir_write   = 1'b0;
    IOR_D      = 1'b0;
    MEM_RD     = 1'b0;
    MEM_WR     = 1'b0;
    REG_DST    = 1'b0;
    MEM_TO_REG = 1'b0;
    REG_WRITE  = 1'b0;
    ALU_SRC_A  = 1'b0;
    ALU_SRC_B  = 2'b00;
    ALU_SEL    = 3'b000;
    PC_SRC     = 2'b00;
    ILLEGAL    = 1'b0;
    case (state_q)
      FETCH: begin
        MEM_RD    = 1'b1;
        ALU_SRC_B = 2'b01;
        ir_write  = MEM_READY;
        pc_en     = MEM_READY;
        state_d   = MEM_READY ? DECODE : FETCH;
      end
      DECODE: begin
        ALU_SRC_B = 2'b11;
        case (OPCODE)
          6'b000000:            state_d = EXEC_R;
          6'b100011, 6'b101011: state_d = MEM_ADDR;
          6'b000100, 6'b000101: state_d = BRANCH;
          6'b001000, 6'b001010: state_d = EXEC_I;
`ifdef MIPS_JUMP_EN
          6'b000010:            state_d = JUMP;
`endif
          default:              ILLEGAL = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = 2'b10;
        state_d   = (OPCODE == 6'b101011) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MEM_RD  = 1'b1;
        IOR_D   = 1'b1;
        state_d = MEM_READY ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        REG_WRITE  = 1'b1;
        MEM_TO_REG = 1'b1;
      end
      MEM_WRITE: begin
        MEM_WR  = 1'b1;
        IOR_D   = 1'b1;
        state_d = MEM_READY ? FETCH : MEM_WRITE;
      end
      EXEC_R: begin
        ALU_SRC_A = 1'b1;
        state_d   = R_WB;
        case (FUNCT)
          6'b100000: ALU_SEL = 3'b000;
          6'b100010: ALU_SEL = 3'b001;
          6'b100100: ALU_SEL = 3'b010;
          6'b100101: ALU_SEL = 3'b011;
          6'b100110: ALU_SEL = 3'b100;
          6'b101010: ALU_SEL = 3'b111;
          default: begin
            ILLEGAL = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      R_WB: begin
        REG_WRITE = 1'b1;
        REG_DST   = 1'b1;
      end
      BRANCH: begin
        ALU_SRC_A = 1'b1;
        ALU_SEL   = 3'b001;
        PC_SRC    = 2'b01;
        pc_en     = (OPCODE == 6'b000101) ? ~ZERO : ZERO;
      end
      EXEC_I: begin
        ALU_SRC_A = 1'b1;
        ALU_SRC_B = 2'b10;
        ALU_SEL   = (OPCODE == 6'b001010) ? 3'b111 : 3'b000;
        state_d   = I_WB;
      end
      I_WB: REG_WRITE = 1'b1;
`ifdef MIPS_JUMP_EN
      JUMP: begin
        PC_SRC = 2'b10;
        pc_en  = 1'b1;
      end
`endif
      default: state_d = FETCH;
    endcase
  end
  // FETCH's enables follow MEM_READY, so they must be masked while reset is held
  assign PC_EN    = pc_en & RST_N;
  assign IR_WRITE = ir_write & RST_N;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed-vector bench for the multicycle control FSM.
module tb_mips_multicycle_control;
  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] OPCODE, FUNCT;
  logic       ZERO, MEM_READY;
  logic       PC_EN, IR_WRITE, IOR_D, MEM_RD, MEM_WR, REG_DST, MEM_TO_REG, REG_WRITE, ALU_SRC_A, ILLEGAL;
  logic [1:0] ALU_SRC_B, PC_SRC;
  logic [2:0] ALU_SEL;
  int checks = 0;
  int errors = 0;
  mips_multicycle_control dut (
    .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .FUNCT(FUNCT), .ZERO(ZERO),
    .MEM_READY(MEM_READY), .PC_EN(PC_EN), .IR_WRITE(IR_WRITE), .IOR_D(IOR_D),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .REG_DST(REG_DST), .MEM_TO_REG(MEM_TO_REG),
    .REG_WRITE(REG_WRITE), .ALU_SRC_A(ALU_SRC_A), .ALU_SRC_B(ALU_SRC_B),
    .ALU_SEL(ALU_SEL), .PC_SRC(PC_SRC), .ILLEGAL(ILLEGAL)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge CLK);
    #2;
  endtask
  task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
    OPCODE = op;
    FUNCT = fn;
    MEM_READY = 1'b1;
    ZERO = 1'b0;
    #1;
    check("fetch_mem_rd", MEM_RD, 1);
    check("fetch_src_b", ALU_SRC_B, 2'b01);
    check("fetch_ir_write", IR_WRITE, 1);
    check("fetch_pc_en", PC_EN, 1);
    cyc;
    check("decode_src_b", ALU_SRC_B, 2'b11);
  endtask
  logic [5:0] r_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b101010};
  logic [2:0] r_op [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
  initial begin
    RST_N = 1'b0;
    OPCODE = 6'd0;
    FUNCT = 6'd0;
    ZERO = 1'b0;
    MEM_READY = 1'b1;
    #3;
    check("rst_mem_rd", MEM_RD, 1);
    check("rst_src_b", ALU_SRC_B, 2'b01);
    check("rst_pc_en", PC_EN, 0);
    check("rst_ir_write", IR_WRITE, 0);
    check("rst_reg_write", REG_WRITE, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    // R-type: four cycles each, next fetch confirms the count
    for (int i = 0; i < 6; i++) begin
      fetch(6'b000000, r_fn[i]);
      cyc;
      check("exec_r_sel", ALU_SEL, r_op[i]);
      check("exec_r_src_a", ALU_SRC_A, 1);
      check("exec_r_src_b", ALU_SRC_B, 2'b00);
      check("exec_r_illegal", ILLEGAL, 0);
      cyc;
      check("r_wb_reg_write", REG_WRITE, 1);
      check("r_wb_reg_dst", REG_DST, 1);
      check("r_wb_mem_to_reg", MEM_TO_REG, 0);
      cyc;
    end
    // fetch stall
    MEM_READY = 1'b0;
    #1;
    check("fstall_ir_write", IR_WRITE, 0);
    check("fstall_pc_en", PC_EN, 0);
    cyc;
    check("fstall_mem_rd", MEM_RD, 1);
    check("fstall_src_b", ALU_SRC_B, 2'b01);
    // lw with three wait cycles in MEM_READ
    fetch(6'b100011, 6'd0);
    cyc;
    check("mem_addr_src_a", ALU_SRC_A, 1);
    check("mem_addr_src_b", ALU_SRC_B, 2'b10);
    MEM_READY = 1'b0;
    cyc;
    for (int i = 0; i < 3; i++) begin
      check("lw_wait_mem_rd", MEM_RD, 1);
      check("lw_wait_ior_d", IOR_D, 1);
      check("lw_wait_reg_write", REG_WRITE, 0);
      cyc;
    end
    MEM_READY = 1'b1;
    #1;
    check("lw_done_mem_rd", MEM_RD, 1);
    check("lw_done_ior_d", IOR_D, 1);
    cyc;
    check("mem_wb_reg_write", REG_WRITE, 1);
    check("mem_wb_mem_to_reg", MEM_TO_REG, 1);
    check("mem_wb_reg_dst", REG_DST, 0);
    cyc;
    check("lw_back_ior_d", IOR_D, 0);
    // sw
    fetch(6'b101011, 6'd0);
    cyc;
    cyc;
    check("sw_mem_wr", MEM_WR, 1);
    check("sw_ior_d", IOR_D, 1);
    check("sw_mem_rd", MEM_RD, 0);
    cyc;
    // beq taken
    fetch(6'b000100, 6'd0);
    cyc;
    ZERO = 1'b1;
    #1;
    check("beq_pc_en", PC_EN, 1);
    check("beq_pc_src", PC_SRC, 2'b01);
    check("beq_alu_sel", ALU_SEL, 3'b001);
    cyc;
    // bne with ZERO high then low
    fetch(6'b000101, 6'd0);
    cyc;
    ZERO = 1'b1;
    #1;
    check("bne_z1_pc_en", PC_EN, 0);
    ZERO = 1'b0;
    #1;
    check("bne_z0_pc_en", PC_EN, 1);
    cyc;
    // addi / slti
    fetch(6'b001000, 6'd0);
    cyc;
    check("addi_sel", ALU_SEL, 3'b000);
    check("addi_src_b", ALU_SRC_B, 2'b10);
    cyc;
    check("i_wb_reg_write", REG_WRITE, 1);
    check("i_wb_reg_dst", REG_DST, 0);
    cyc;
    fetch(6'b001010, 6'd0);
    cyc;
    check("slti_sel", ALU_SEL, 3'b111);
    cyc;
    cyc;
    // illegal opcode
    fetch(6'b111111, 6'd0);
    check("ill_op_decode", ILLEGAL, 1);
    cyc;
    check("ill_op_after", ILLEGAL, 0);
    // illegal funct
    fetch(6'b000000, 6'b000001);
    check("ill_fn_decode", ILLEGAL, 0);
    cyc;
    check("ill_fn_exec", ILLEGAL, 1);
    check("ill_fn_sel", ALU_SEL, 3'b000);
    check("ill_fn_reg_write", REG_WRITE, 0);
    cyc;
    check("ill_fn_after_reg_write", REG_WRITE, 0);
    // jump
    fetch(6'b000010, 6'd0);
`ifdef MIPS_JUMP_EN
    check("j_decode_illegal", ILLEGAL, 0);
    cyc;
    check("j_pc_en", PC_EN, 1);
    check("j_pc_src", PC_SRC, 2'b10);
    cyc;
`else
    check("j_decode_illegal", ILLEGAL, 1);
    cyc;
`endif
    // reset in the middle of EXEC_R
    fetch(6'b000000, 6'b100000);
    cyc;
    check("pre_rst_src_a", ALU_SRC_A, 1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_mem_rd", MEM_RD, 1);
    check("mid_rst_src_a", ALU_SRC_A, 0);
    check("mid_rst_pc_en", PC_EN, 0);
    cyc;
    check("mid_rst_reg_write", REG_WRITE, 0);
    check("mid_rst_ir_write", IR_WRITE, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("post_rst_ir_write", IR_WRITE, 1);
    cyc;
    check("post_rst_decode", ALU_SRC_B, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
